// File: rtl/finish_sequencer.sv
// End-of-race sequencer: detects a finisher, blinks the FINISH banner for a number
// of frame phases, holds it steady, then requests a restart and waits for positions to clear.
module finish_sequencer #(
  parameter int GOAL_TILE    = 10,
  parameter int BLINK_FRAMES = 15,
  parameter int BLINK_PHASES = 6,
  parameter int HOLD_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       game_active,
  input  logic [3:0] p1_pos,
  input  logic [3:0] p2_pos,
  output logic       finish_en,
  output logic [1:0] winner,
  output logic       restart_req,
  output logic       busy
);

  localparam int FMAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int FW   = (FMAX > 1) ? $clog2(FMAX) : 1;
  localparam int PW   = (BLINK_PHASES > 1) ? $clog2(BLINK_PHASES) : 1;

  localparam logic [3:0]    GOAL       = 4'(GOAL_TILE);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] HOLD_LAST  = FW'(HOLD_FRAMES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_PHASES - 1);
  localparam logic [FW-1:0] F_ONE      = FW'(1);
  localparam logic [PW-1:0] P_ONE      = PW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLINK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] REARM = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic          vsync_d_q, vsync_d_d;
  logic          finish_en_q, finish_en_d;
  logic [1:0]    winner_q, winner_d;
  logic          restart_req_q, restart_req_d;
  logic          busy_q, busy_d;

  logic frame_tick;
  logic p1_hit, p2_hit;

  assign frame_tick = vsync & ~vsync_d_q;
  assign p1_hit     = (p1_pos >= GOAL);
  assign p2_hit     = (p2_pos >= GOAL);

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    phase_cnt_d   = phase_cnt_q;
    finish_en_d   = finish_en_q;
    winner_d      = winner_q;
    restart_req_d = 1'b0;
    vsync_d_d     = vsync;

    case (state_q)
      IDLE: begin
        if (game_active && (p1_hit || p2_hit)) begin
          state_d     = BLINK;
          winner_d    = {p2_hit, p1_hit};
          frame_cnt_d = '0;
          phase_cnt_d = '0;
          finish_en_d = 1'b1;
        end
      end
      BLINK: begin
        if (frame_tick) begin
          if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d = '0;
            // Last phase ends in a steady banner rather than another toggle.
            if (phase_cnt_q == PHASE_LAST) begin
              state_d     = HOLD;
              finish_en_d = 1'b1;
            end else begin
              finish_en_d = ~finish_en_q;
              phase_cnt_d = phase_cnt_q + P_ONE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + F_ONE;
          end
        end
      end
      HOLD: begin
        finish_en_d = 1'b1;
        if (frame_tick) begin
          if (frame_cnt_q == HOLD_LAST) begin
            restart_req_d = 1'b1;
            finish_en_d   = 1'b0;
            frame_cnt_d   = '0;
            state_d       = REARM;
          end else begin
            frame_cnt_d = frame_cnt_q + F_ONE;
          end
        end
      end
      REARM: begin
        // Positions left at the goal from the finished race must not retrigger.
        if (!p1_hit && !p2_hit) begin
          state_d  = IDLE;
          winner_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      phase_cnt_q   <= '0;
      vsync_d_q     <= 1'b0;
      finish_en_q   <= 1'b0;
      winner_q      <= 2'b00;
      restart_req_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      phase_cnt_q   <= phase_cnt_d;
      vsync_d_q     <= vsync_d_d;
      finish_en_q   <= finish_en_d;
      winner_q      <= winner_d;
      restart_req_q <= restart_req_d;
      busy_q        <= busy_d;
    end
  end

  assign finish_en   = finish_en_q;
  assign winner      = winner_q;
  assign restart_req = restart_req_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_finish_sequencer.sv
// Directed bench for finish_sequencer with short blink/hold timing.
module tb_finish_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       game_active;
  logic [3:0] p1_pos;
  logic [3:0] p2_pos;
  logic       finish_en;
  logic [1:0] winner;
  logic       restart_req;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int rr_pulses = 0;

  finish_sequencer #(
    .GOAL_TILE(10), .BLINK_FRAMES(2), .BLINK_PHASES(4), .HOLD_FRAMES(3)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .game_active(game_active),
    .p1_pos(p1_pos), .p2_pos(p2_pos), .finish_en(finish_en), .winner(winner),
    .restart_req(restart_req), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (restart_req === 1'b1) rr_pulses++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: vsync high for hi clocks, then low for one clock.
  task automatic frame(input int hi);
    vsync = 1'b1;
    repeat (hi) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic outs(input string tag, input logic fe, input logic [1:0] w,
                      input logic rr, input logic b);
    check({tag, ".fe"}, 8'(finish_en), 8'(fe));
    check({tag, ".win"}, 8'(winner), 8'(w));
    check({tag, ".rr"}, 8'(restart_req), 8'(rr));
    check({tag, ".busy"}, 8'(busy), 8'(b));
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; game_active = 1'b0; p1_pos = 4'd0; p2_pos = 4'd0;
    clocks(2);
    outs("reset", 1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    clocks(1);

    // Trigger by player 1 stepping 9 -> 10.
    game_active = 1'b1; p1_pos = 4'd9;
    clocks(1);
    outs("pre_goal", 1'b0, 2'b00, 1'b0, 1'b0);
    p1_pos = 4'd10;
    clocks(1);
    outs("trigger", 1'b1, 2'b01, 1'b0, 1'b1);

    // A long vsync high must count as a single tick.
    frame(5);
    check("long_vsync_fe", 8'(finish_en), 8'h1);
    frame(1);
    check("blink_ph1", 8'(finish_en), 8'h0);
    // Inputs changing mid-sequence are ignored.
    game_active = 1'b0; p1_pos = 4'd3; p2_pos = 4'd10;
    frame(1); frame(1);
    check("blink_ph2", 8'(finish_en), 8'h1);
    check("blink_win", 8'(winner), 8'h1);
    frame(1); frame(1);
    check("blink_ph3", 8'(finish_en), 8'h0);
    game_active = 1'b1; p1_pos = 4'd10; p2_pos = 4'd10;
    frame(1);
    check("blink_ph3_mid", 8'(finish_en), 8'h0);
    frame(1);
    outs("hold_enter", 1'b1, 2'b01, 1'b0, 1'b1);
    // No ticks: state and banner must stay put.
    clocks(20);
    check("hold_stall", 8'(finish_en), 8'h1);
    frame(1); frame(1);
    outs("hold_2", 1'b1, 2'b01, 1'b0, 1'b1);
    vsync = 1'b1;
    clocks(1);
    outs("restart", 1'b0, 2'b01, 1'b1, 1'b1);
    vsync = 1'b0;
    clocks(1);
    outs("rearm", 1'b0, 2'b01, 1'b0, 1'b1);

    // Stale positions at the goal must not start another sequence.
    for (int i = 0; i < 10; i++) frame(1);
    outs("rearm_stale", 1'b0, 2'b01, 1'b0, 1'b1);
    check("rr_count_1", 8'(rr_pulses), 8'd1);

    p1_pos = 4'd0; p2_pos = 4'd0;
    clocks(1);
    outs("rearm_exit", 1'b0, 2'b00, 1'b0, 1'b0);
    p2_pos = 4'd10;
    clocks(1);
    outs("p2_trigger", 1'b1, 2'b10, 1'b0, 1'b1);

    // Run into HOLD, then reset aborts without a restart pulse.
    for (int i = 0; i < 9; i++) frame(1);
    outs("p2_hold", 1'b1, 2'b10, 1'b0, 1'b1);
    reset = 1'b1; p2_pos = 4'd0;
    clocks(1);
    outs("hold_reset", 1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) frame(1);
    outs("post_reset", 1'b0, 2'b00, 1'b0, 1'b0);
    check("rr_count_2", 8'(rr_pulses), 8'd1);

    // Goal reached while the race is not active is ignored.
    game_active = 1'b0; p2_pos = 4'd10;
    clocks(3);
    outs("inactive", 1'b0, 2'b00, 1'b0, 1'b0);
    p2_pos = 4'd0;
    clocks(1);

    // Both players arrive in the same cycle.
    game_active = 1'b1; p1_pos = 4'd10; p2_pos = 4'd10;
    clocks(1);
    outs("tie", 1'b1, 2'b11, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
